// File: rtl/ovcam_fb_scanner.sv
// OV camera frame-buffer read-port arbiter and raster scanner.
// Software owns the read port at idle; a scan streams a frame over AXI-Stream.
module ovcam_fb_scanner #(
   parameter int H_RES  = 320,
   parameter int V_RES  = 240,
   parameter int RD_LAT = 2
) (
   input  logic       ACLK,
   input  logic       ARESETN,
   input  logic       start,
   input  logic [9:0] sw_xLoc,
   input  logic [9:0] sw_yLoc,
   input  logic       i2c_ready,
   input  logic [7:0] pixel_out,
   output logic [9:0] fb_xLoc,
   output logic [9:0] fb_yLoc,
   output logic [7:0] m_tdata,
   output logic       m_tvalid,
   input  logic       m_tready,
   output logic       m_tlast,
   output logic       m_tuser,
   output logic       busy,
   output logic       done,
   output logic       aborted
);

   localparam logic [9:0] X_MAX = 10'(H_RES - 1);
   localparam logic [9:0] Y_MAX = 10'(V_RES - 1);
   localparam logic [3:0] LAT   = 4'(RD_LAT);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      OUT,
      FIN
   } state_t;

   state_t     state, state_nx;
   logic [9:0] x, y, x_nx, y_nx;
   logic [3:0] wcnt, wcnt_nx;
   logic [7:0] tdata_nx;
   logic       tvalid_nx, tlast_nx, tuser_nx, aborted_nx;
   logic       last_px;

   assign busy    = (state == ADDR) || (state == OUT);
   assign done    = (state == FIN);
   assign fb_xLoc = busy ? x : sw_xLoc;
   assign fb_yLoc = busy ? y : sw_yLoc;
   assign last_px = (x == X_MAX) && (y == Y_MAX);

   // State register plus counters and the registered stream beat.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state    <= IDLE;
         x        <= '0;
         y        <= '0;
         wcnt     <= '0;
         m_tdata  <= '0;
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
         m_tuser  <= 1'b0;
         aborted  <= 1'b0;
      end else begin
         state    <= state_nx;
         x        <= x_nx;
         y        <= y_nx;
         wcnt     <= wcnt_nx;
         m_tdata  <= tdata_nx;
         m_tvalid <= tvalid_nx;
         m_tlast  <= tlast_nx;
         m_tuser  <= tuser_nx;
         aborted  <= aborted_nx;
      end
   end

   // Next-state: wait out read latency, hold beat until accepted, advance.
   always_comb begin
      state_nx   = state;
      x_nx       = x;
      y_nx       = y;
      wcnt_nx    = wcnt;
      tdata_nx   = m_tdata;
      tvalid_nx  = m_tvalid;
      tlast_nx   = m_tlast;
      tuser_nx   = m_tuser;
      aborted_nx = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && i2c_ready) begin
               x_nx     = '0;
               y_nx     = '0;
               wcnt_nx  = LAT;
               state_nx = ADDR;
            end
         end
         ADDR: begin
            if (!i2c_ready) begin
               x_nx       = '0;
               y_nx       = '0;
               aborted_nx = 1'b1;
               state_nx   = IDLE;
            end else if (wcnt == 4'd0) begin
               tdata_nx  = pixel_out;
               tvalid_nx = 1'b1;
               tlast_nx  = (x == X_MAX);
               tuser_nx  = (x == 10'd0) && (y == 10'd0);
               state_nx  = OUT;
            end else begin
               wcnt_nx = wcnt - 4'd1;
            end
         end
         OUT: begin
            if (m_tready) begin
               tvalid_nx = 1'b0;
               tlast_nx  = 1'b0;
               tuser_nx  = 1'b0;
               if (last_px) begin
                  x_nx     = '0;
                  y_nx     = '0;
                  state_nx = FIN;
               end else if (!i2c_ready) begin
                  x_nx       = '0;
                  y_nx       = '0;
                  aborted_nx = 1'b1;
                  state_nx   = IDLE;
               end else begin
                  if (x == X_MAX) begin
                     x_nx = '0;
                     y_nx = y + 10'd1;
                  end else begin
                     x_nx = x + 10'd1;
                  end
                  wcnt_nx  = LAT;
                  state_nx = ADDR;
               end
            end
         end
         FIN: begin
            x_nx     = '0;
            y_nx     = '0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule
